mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 1024x8 byte-addressed, 16-bit-word memory (mem) between NUM_REQ requesters.
//  Requesters include the sink-table updater, the Q-value learner and the packet handler.
//  Round-robin arbitration, at most one word access per cycle.
//  Supports a bounded lock so read-modify-write sequences on table entries (e.g. qValue, batteryStat) are atomic.
//  Sits between the requesters and mem; drives mem's address/wr_en/data_in and registers its data_out.
// PARAMETERS
//  NUM_REQ    4     number of requesters (2..8)
//  WORD_W     16    word/address width, matches mem
//  MEM_DEPTH  1024  memory depth in bytes; legal word address range 0..MEM_DEPTH-2
//  LOCK_MAX   16    max consecutive cycles one owner may hold the lock
// PORTS
//  clock         in   1               rising-edge clock, shared with mem
//  reset         in   1               asynchronous, active-high reset
//  req           in   NUM_REQ         request, one bit per requester
//  lock          in   NUM_REQ         keep grant after this access (RMW)
//  we            in   NUM_REQ         1=write word, 0=read word
//  addr          in   NUM_REQ*WORD_W  byte address; requester i at [i*WORD_W +: WORD_W]
//  wdata         in   NUM_REQ*WORD_W  write data, same packing as addr
//  gnt           out  NUM_REQ         one-hot; access performed this cycle
//  rvalid        out  NUM_REQ         one-hot; read data valid on rdata this cycle
//  rdata         out  WORD_W          registered read data
//  err           out  NUM_REQ         one-hot; previous granted access was out of range
//  lock_timeout  out  1               lock forcibly released this cycle
//  mem_address   out  WORD_W          to mem address
//  mem_wr_en     out  1               to mem wr_en
//  mem_data_in   out  WORD_W          to mem data_in
//  mem_data_out  in   WORD_W          from mem data_out (combinational read)
// BEHAVIOUR
//  Reset:
//   - gnt, rvalid, err, lock_timeout, rdata are 0; rr pointer=0; state IDLE; lock counter=0.
//   - mem_wr_en is forced 0 combinationally while reset=1.
//  Requester rules:
//   - Requester holds req/we/addr/wdata/lock stable until it sees gnt.
//   - Requester may drop req before gnt; the request is withdrawn.
//  Grant:
//   - gnt is combinational in cycle T.
//   - IDLE: winner is the first set req bit searching from ptr upward, wrapping.
//   - LOCKED: only owner may win; other reqs wait.
//   - No gnt when winner set is empty.
//  Memory drive in T:
//   - mem_address = winner addr; mem_data_in = winner wdata.
//   - mem_wr_en = winner we & in_range. Write commits at the clock edge ending T.
//   - With no winner: mem_address=0, mem_data_in=0, mem_wr_en=0.
//  Range check:
//   - in_range = (addr <= MEM_DEPTH-2). Odd addresses are legal (byte-granular map).
//  Read response (cycle T+1), latency 1:
//   - Read, in range: rdata <= mem_data_out; rvalid[i]=1 in T+1.
//   - Read, out of range: rdata <= 0, rvalid[i]=1, err[i]=1 in T+1.
//   - Write, out of range: no memory write; err[i]=1 in T+1. No rvalid for writes.
//   - rdata holds its value when no read response is issued.
//  Pointer: after a grant to i in IDLE with lock[i]=0, ptr <= (i+1) mod NUM_REQ.
//  Lock FSM (IDLE/LOCKED):
//   - IDLE->LOCKED when winner i has lock[i]=1: owner <= i, cnt <= 1.
//   - LOCKED, each cycle: cnt <= cnt+1.
//   - LOCKED->IDLE when owner is granted with lock=0 (that access still performed).
//   - LOCKED->IDLE when owner drops req.
//   - LOCKED->IDLE on forced release: cnt reaches LOCK_MAX; lock_timeout=1 for that cycle and no gnt issued that cycle.
//   - On every exit: ptr <= (owner+1) mod NUM_REQ; cnt <= 0.
//  Simultaneous events:
//   - Owner re-request with lock=1 at cnt=LOCK_MAX-1 is granted; the next cycle is the forced release.
//   - Reset asserted mid-lock returns to IDLE immediately and drops any pending rvalid/err.
// TESTING
//  1. reset, req=4'b0001 read addr 0x08 (mem 0x00,0x0F) -> gnt=0001 in T; rvalid=0001, rdata=0x000F in T+1.
//  2. req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... (fair rotation).
//  3. req1 write 0x0148<=0xBEEF, then read 0x0148 -> mem_wr_en=1 in write cycle only; read returns 0xBEEF.
//  4. req0 read addr 0x03FF; req2 write 0x0400 -> both granted; err pulses 1 cycle later; mem unchanged; rdata=0.
//  5. req0 lock=1 read 0x01C8, req3 pending; req0 writes with lock=0 on the 3rd cycle -> req3 is not granted until after req0's write; next gnt=1000.
//  6. req1 holds lock=1 continuously -> lock_timeout=1 at cnt=16, no gnt that cycle; req2 (pending) granted next cycle.
//     Repeat with reset pulsed mid-lock -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one byte-addressed, 16-bit-word memory among NUM_REQ requesters.
// A bounded lock keeps the grant with one owner so read-modify-write sequences stay atomic.
module mem_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int WORD_W    = 16,
   parameter int MEM_DEPTH = 1024,
   parameter int LOCK_MAX  = 16
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ-1:0]        i_lock,
   input  logic [NUM_REQ-1:0]        i_we,
   input  logic [NUM_REQ*WORD_W-1:0] i_addr,
   input  logic [NUM_REQ*WORD_W-1:0] i_wdata,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic [NUM_REQ-1:0]        o_rvalid,
   output logic [WORD_W-1:0]         o_rdata,
   output logic [NUM_REQ-1:0]        o_err,
   output logic                      o_lock_timeout,
   output logic [WORD_W-1:0]         o_mem_address,
   output logic                      o_mem_wr_en,
   output logic [WORD_W-1:0]         o_mem_data_in,
   input  logic [WORD_W-1:0]         i_mem_data_out,
   output logic                      o_dbg_state
);

   // Handshake: a requester raises i_req with stable we/addr/wdata/lock; o_gnt in the same cycle
   // means the access is taken at the closing edge. Dropping i_req before o_gnt withdraws it.

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_REQ-1:0]  r_rvalid;
   logic [NUM_REQ-1:0]  r_err;
   logic [WORD_W-1:0]   r_rdata;

   logic                w_timeout;
   logic [NUM_REQ-1:0]  w_cand;
   logic                w_win_vld;
   logic [IDX_W-1:0]    w_win_idx;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [WORD_W-1:0]   w_addr;
   logic [WORD_W-1:0]   w_wdata;
   logic                w_we;
   logic                w_lock;
   logic                w_in_range;

   function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
   endfunction

   assign w_timeout = (r_state == ST_LOCKED) && (r_cnt == CNT_W'(LOCK_MAX));

   // While locked only the owner is eligible, and nobody is during the forced-release cycle.
   always_comb begin
      w_cand = '0;
      if (i_reset) begin
         w_cand = '0;
      end else if (r_state == ST_IDLE) begin
         w_cand = i_req;
      end else if (!w_timeout) begin
         w_cand = i_req & (NUM_REQ'(1) << r_owner);
      end
   end

   always_comb begin : rr_search
      int j;
      j         = 0;
      w_win_vld = 1'b0;
      w_win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!w_win_vld && w_cand[j]) begin
            w_win_vld = 1'b1;
            w_win_idx = IDX_W'(j);
         end
      end
   end

   assign w_gnt      = w_win_vld ? (NUM_REQ'(1) << w_win_idx) : '0;
   assign w_addr     = i_addr[w_win_idx*WORD_W +: WORD_W];
   assign w_wdata    = i_wdata[w_win_idx*WORD_W +: WORD_W];
   assign w_we       = i_we[w_win_idx];
   assign w_lock     = i_lock[w_win_idx];
   assign w_in_range = (w_addr <= WORD_W'(MEM_DEPTH - 2));

   assign o_gnt          = w_gnt;
   assign o_mem_address  = w_win_vld ? w_addr  : '0;
   assign o_mem_data_in  = w_win_vld ? w_wdata : '0;
   assign o_mem_wr_en    = w_win_vld & w_we & w_in_range & ~i_reset;
   assign o_lock_timeout = w_timeout;
   assign o_rvalid       = r_rvalid;
   assign o_err          = r_err;
   assign o_rdata        = r_rdata;
   assign o_dbg_state    = (r_state == ST_LOCKED);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_cnt    <= '0;
         r_rvalid <= '0;
         r_err    <= '0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= (w_win_vld && !w_we) ? w_gnt : '0;
         r_err    <= (w_win_vld && !w_in_range) ? w_gnt : '0;
         if (w_win_vld && !w_we) begin
            r_rdata <= w_in_range ? i_mem_data_out : '0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_win_vld) begin
                  if (w_lock) begin
                     r_state <= ST_LOCKED;
                     r_owner <= w_win_idx;
                     r_cnt   <= CNT_W'(1);
                  end else begin
                     r_ptr <= f_next(w_win_idx);
                  end
               end
            end
            ST_LOCKED: begin
               // Exit on forced release, owner withdrawal, or a final unlocked access.
               if (w_timeout || !w_win_vld || !w_lock) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= f_next(r_owner);
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized requesters, all checked cycle by cycle
// against a rule-level reference model with its own byte memory image.
module tb_mem_arbiter;

   localparam int NR       = 4;
   localparam int LOCK_MAX = 16;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   req;
   logic [NR-1:0]   lock;
   logic [NR-1:0]   we;
   logic [NR*16-1:0] addr_bus;
   logic [NR*16-1:0] wdata_bus;
   logic [NR-1:0]   dut_gnt;
   logic [NR-1:0]   dut_rvalid;
   logic [15:0]     dut_rdata;
   logic [NR-1:0]   dut_err;
   logic            dut_tmo;
   logic [15:0]     dut_mem_address;
   logic            dut_mem_wr_en;
   logic [15:0]     dut_mem_data_in;
   logic [15:0]     dut_mem_data_out;
   logic            dut_state;

   logic [7:0]      env_mem [0:1023];
   logic [7:0]      ref_mem [0:1023];

   // reference model state
   int              m_ptr;
   int              m_owner;
   int              m_held;
   logic [NR-1:0]   exp_rvalid;
   logic [NR-1:0]   exp_err;
   logic [15:0]     exp_rdata;
   logic [15:0]     exp_q[$];

   logic [NR-1:0]   obs_gnt;
   logic            obs_wr_en;
   logic            obs_tmo;
   logic [NR-1:0]   err_seen;

   int              n_checks;
   int              n_errors;

   mem_arbiter #(.NUM_REQ(NR), .WORD_W(16), .MEM_DEPTH(1024), .LOCK_MAX(LOCK_MAX)) u_dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_req          (req),
      .i_lock         (lock),
      .i_we           (we),
      .i_addr         (addr_bus),
      .i_wdata        (wdata_bus),
      .o_gnt          (dut_gnt),
      .o_rvalid       (dut_rvalid),
      .o_rdata        (dut_rdata),
      .o_err          (dut_err),
      .o_lock_timeout (dut_tmo),
      .o_mem_address  (dut_mem_address),
      .o_mem_wr_en    (dut_mem_wr_en),
      .o_mem_data_in  (dut_mem_data_in),
      .i_mem_data_out (dut_mem_data_out),
      .o_dbg_state    (dut_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // memory beside the arbiter: big-endian word, combinational read
   assign dut_mem_data_out = (dut_mem_address <= 16'd1022) ?
      {env_mem[dut_mem_address[9:0]], env_mem[10'(dut_mem_address + 16'd1)]} : 16'hDEAD;

   always @(posedge clk) begin
      if (dut_mem_wr_en && dut_mem_address <= 16'd1022) begin
         env_mem[dut_mem_address[9:0]]          = dut_mem_data_in[15:8];
         env_mem[10'(dut_mem_address + 16'd1)]  = dut_mem_data_in[7:0];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic set_txn(input int i, input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic l);
      req[i]               = r;
      we[i]                = w;
      lock[i]              = l;
      addr_bus[i*16 +: 16]  = a;
      wdata_bus[i*16 +: 16] = d;
   endtask

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 16'd1022;
         1:       return 16'd1023;
         2:       return 16'($urandom_range(1024, 65535));
         3:       return 16'($urandom_range(0, 1022));
         default: return 16'($urandom_range(0, 31));
      endcase
   endfunction

   task automatic new_txn(input int i, input logic cont);
      logic l;
      l = cont ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
      set_txn(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom_range(0, 65535)), l);
   endtask

   task automatic rand_drive();
      for (int i = 0; i < NR; i++) begin
         if (obs_gnt[i]) begin
            if (lock[i] && $urandom_range(0, 7) != 0) new_txn(i, 1'b1);
            else if ($urandom_range(0, 2) == 0) new_txn(i, 1'b0);
            else begin req[i] = 1'b0; lock[i] = 1'b0; end
         end else if (req[i]) begin
            if ($urandom_range(0, 31) == 0) begin req[i] = 1'b0; lock[i] = 1'b0; end
         end else if ($urandom_range(0, 2) == 0) begin
            new_txn(i, 1'b0);
         end
      end
   endtask

   task automatic model_reset();
      m_ptr      = 0;
      m_owner    = -1;
      m_held     = 0;
      exp_rvalid = '0;
      exp_err    = '0;
      exp_rdata  = '0;
      exp_q.delete();
      obs_gnt    = '0;
   endtask

   // Asserted a little after an edge, so it also lands mid-cycle when a lock is held.
   task automatic reset_dut();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) set_txn(i, 1'b1, 1'b1, 16'(i * 4), 16'hA5A5, 1'b0);
      @(negedge clk);
      check_eq("rst_gnt", 32'(dut_gnt), 32'd0);
      check_eq("rst_rvalid", 32'(dut_rvalid), 32'd0);
      check_eq("rst_err", 32'(dut_err), 32'd0);
      check_eq("rst_rdata", 32'(dut_rdata), 32'd0);
      check_eq("rst_tmo", 32'(dut_tmo), 32'd0);
      check_eq("rst_wr_en", 32'(dut_mem_wr_en), 32'd0);
      check_eq("rst_state", 32'(dut_state), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0; we = '0; lock = '0;
      model_reset();
   endtask

   // One cycle: compare DUT against the model at the falling edge, then advance the model.
   task automatic step_cycle();
      int          win;
      logic        tmo;
      logic        in_rng;
      logic [15:0] a;
      logic [15:0] d;
      logic [NR-1:0] exp_gnt;
      @(negedge clk);
      check_eq("rvalid", 32'(dut_rvalid), 32'(exp_rvalid));
      check_eq("err", 32'(dut_err), 32'(exp_err));
      err_seen = err_seen | dut_err;
      if (exp_rvalid != '0 && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
      check_eq("rdata", 32'(dut_rdata), 32'(exp_rdata));

      win = -1;
      tmo = (m_owner >= 0) && (m_held >= LOCK_MAX);
      if (m_owner < 0) begin
         for (int k = 0; k < NR; k++) begin
            if (win < 0 && req[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
         end
      end else if (!tmo && req[m_owner]) begin
         win = m_owner;
      end
      a = 16'h0; d = 16'h0; exp_gnt = '0; in_rng = 1'b0;
      if (win >= 0) begin
         a = addr_bus[win*16 +: 16];
         d = wdata_bus[win*16 +: 16];
         exp_gnt[win] = 1'b1;
         in_rng = (a <= 16'd1022);
      end
      check_eq("gnt", 32'(dut_gnt), 32'(exp_gnt));
      check_eq("lock_timeout", 32'(dut_tmo), 32'(tmo));
      check_eq("mem_wr_en", 32'(dut_mem_wr_en), 32'(win >= 0 && we[win] && in_rng));
      check_eq("mem_address", 32'(dut_mem_address), 32'(a));
      check_eq("mem_data_in", 32'(dut_mem_data_in), 32'(d));
      obs_gnt   = dut_gnt;
      obs_wr_en = dut_mem_wr_en;
      obs_tmo   = dut_tmo;

      exp_rvalid = '0;
      exp_err    = '0;
      if (win >= 0) begin
         if (!we[win]) begin
            exp_rvalid[win] = 1'b1;
            exp_q.push_back(in_rng ? {ref_mem[a[9:0]], ref_mem[10'(a + 16'd1)]} : 16'h0);
         end
         if (!in_rng) exp_err[win] = 1'b1;
         else if (we[win]) begin
            ref_mem[a[9:0]]         = d[15:8];
            ref_mem[10'(a + 16'd1)] = d[7:0];
         end
      end

      if (m_owner < 0) begin
         if (win >= 0) begin
            if (lock[win]) begin m_owner = win; m_held = 1; end
            else m_ptr = (win + 1) % NR;
         end
      end else if (tmo || win < 0 || !lock[m_owner]) begin
         m_ptr   = (m_owner + 1) % NR;
         m_owner = -1;
         m_held  = 0;
      end else begin
         m_held++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (req != '0 && n < budget) begin
         step_cycle();
         req = req & ~(obs_gnt & ~lock);
         n++;
      end
      check_eq("drain_done", 32'(req), 32'd0);
      step_cycle();
   endtask

   initial begin
      logic [NR-1:0] g [4];
      logic [7:0]    sv_hi;
      logic [7:0]    sv_lo;
      int            diff;
      n_checks = 0;
      n_errors = 0;
      err_seen = '0;
      rst = 1'b1;
      req = '0; lock = '0; we = '0; addr_bus = '0; wdata_bus = '0;
      for (int i = 0; i < 1024; i++) begin
         env_mem[i] = 8'($urandom_range(0, 255));
         ref_mem[i] = env_mem[i];
      end
      env_mem[8] = 8'h00; ref_mem[8] = 8'h00;
      env_mem[9] = 8'h0F; ref_mem[9] = 8'h0F;
      model_reset();

      // single read, latency one
      reset_dut();
      set_txn(0, 1'b1, 1'b0, 16'h0008, 16'h0, 1'b0);
      step_cycle();
      check_eq("t1_gnt", 32'(obs_gnt), 32'h1);
      req = '0;
      check_eq("t1_rvalid", 32'(dut_rvalid), 32'h1);
      check_eq("t1_rdata", 32'(dut_rdata), 32'h000F);
      step_cycle();

      // fair rotation with all four requesting
      reset_dut();
      for (int i = 0; i < NR; i++) set_txn(i, 1'b1, 1'b0, 16'(i * 2 + 16), 16'h0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step_cycle();
         check_eq("t2_rot", 32'(obs_gnt), 32'(1 << (k % 4)));
      end
      req = '0;
      step_cycle();

      // write then read back
      set_txn(1, 1'b1, 1'b1, 16'h0148, 16'hBEEF, 1'b0);
      step_cycle();
      check_eq("t3_wr_en_w", 32'(obs_wr_en), 32'd1);
      set_txn(1, 1'b1, 1'b0, 16'h0148, 16'h0, 1'b0);
      step_cycle();
      check_eq("t3_wr_en_r", 32'(obs_wr_en), 32'd0);
      check_eq("t3_rdata", 32'(dut_rdata), 32'hBEEF);
      req = '0;
      step_cycle();

      // out-of-range read and write
      sv_hi = env_mem[1022];
      sv_lo = env_mem[1023];
      err_seen = '0;
      set_txn(0, 1'b1, 1'b0, 16'h03FF, 16'h0, 1'b0);
      set_txn(2, 1'b1, 1'b1, 16'h0400, 16'h1234, 1'b0);
      drain(8);
      check_eq("t4_err", 32'(err_seen), 32'h5);
      check_eq("t4_rdata", 32'(dut_rdata), 32'h0);
      check_eq("t4_mem", {16'h0, env_mem[1022], env_mem[1023]}, {16'h0, sv_hi, sv_lo});

      // locked read-modify-write keeps req3 waiting
      reset_dut();
      set_txn(0, 1'b1, 1'b0, 16'h01C8, 16'h0, 1'b1);
      set_txn(3, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
      step_cycle(); g[0] = obs_gnt;
      step_cycle(); g[1] = obs_gnt;
      set_txn(0, 1'b1, 1'b1, 16'h01C8, 16'h5A5A, 1'b0);
      step_cycle(); g[2] = obs_gnt;
      req[0] = 1'b0;
      step_cycle(); g[3] = obs_gnt;
      req[3] = 1'b0;
      step_cycle();
      check_eq("t5_g0", 32'(g[0]), 32'h1);
      check_eq("t5_g1", 32'(g[1]), 32'h1);
      check_eq("t5_g2", 32'(g[2]), 32'h1);
      check_eq("t5_g3", 32'(g[3]), 32'h8);

      // lock held past LOCK_MAX is forcibly released
      reset_dut();
      set_txn(1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
      set_txn(2, 1'b1, 1'b0, 16'h0022, 16'h0, 1'b0);
      for (int k = 0; k < 18; k++) begin
         step_cycle();
         if (k == 15) check_eq("t6_last_gnt", 32'(obs_gnt), 32'h2);
         if (k == 16) begin
            check_eq("t6_tmo", 32'(obs_tmo), 32'd1);
            check_eq("t6_tmo_gnt", 32'(obs_gnt), 32'd0);
         end
         if (k == 17) check_eq("t6_next", 32'(obs_gnt), 32'h4);
      end
      req[2] = 1'b0;
      step_cycle();
      step_cycle();
      check_eq("t6_relock", 32'(dut_state), 32'd1);
      reset_dut();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rand_drive();
         step_cycle();
      end
      req = '0; lock = '0;
      step_cycle();
      step_cycle();

      diff = 0;
      for (int i = 0; i < 1024; i++) if (env_mem[i] !== ref_mem[i]) diff++;
      check_eq("mem_image", 32'(diff), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
